// File: rtl/mux_test_pkg.sv
// Shared types and constants for the mux response checker.
package mux_test_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned SEL_W  = 3;
   localparam logic [NUM_CH-1:0] DATA_PATTERN_DEF = 8'hA5;

   // Level the mux output should drive for a given select stimulus.
   function automatic logic expected_y(input logic [NUM_CH-1:0] pat,
                                       input logic              en,
                                       input logic [SEL_W-1:0]  sel);
      return en & pat[sel];
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_chain <= '0;
      else     r_chain <= {r_chain[STAGES-2:0], i_d};
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/mux_response_checker.sv
// Checks the mux IC output against the select stimulus once the pin has settled
// and accumulates per-channel pass/fail status and a saturating error count.
module mux_response_checker
   import mux_test_pkg::*;
#(
   parameter logic [NUM_CH-1:0] DATA_PATTERN = DATA_PATTERN_DEF,
   parameter int unsigned       SYNC_STAGES  = 2,
   parameter int unsigned       DUT_LAT      = 1,
   parameter int unsigned       ERR_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              en,
   input  logic [SEL_W-1:0]  sel,
   input  logic              y,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [NUM_CH-1:0] ch_ok,
   output logic [NUM_CH-1:0] ch_bad
);

   localparam int unsigned D      = SYNC_STAGES + DUT_LAT;
   localparam int unsigned STAB_W = $clog2(D + 1);
   localparam int unsigned STIM_W = SEL_W + 1;

   state_t              r_state, w_state_next;
   logic [STIM_W-1:0]   r_prev_stim;
   logic [STAB_W-1:0]   r_stab;
   logic [ERR_W-1:0]    r_err_cnt, w_err_next;
   logic                r_fail, w_fail_next;
   logic [NUM_CH-1:0]   r_ch_ok, w_ch_ok_next;
   logic [NUM_CH-1:0]   r_ch_bad, w_ch_bad_next;
   logic                r_off_seen, w_off_seen_next;
   logic                r_busy, r_done, r_pass;
   logic                w_busy_next, w_done_next, w_pass_next;

   logic [STIM_W-1:0]   w_stim;
   logic                w_chg;
   logic [STAB_W-1:0]   w_stab;
   logic                w_exp;
   logic                w_cmp;
   logic                w_mis;
   logic                w_y_s;

   sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (y),
      .o_q (w_y_s)
   );

   // Settle tracking: stab counts consecutive cycles of unchanged stimulus in RUN.
   always_comb begin
      w_stim = {en, sel};
      w_chg  = (w_stim != r_prev_stim);
      w_stab = '0;
      if (r_state == RUN && !w_chg) begin
         w_stab = (r_stab == STAB_W'(D)) ? r_stab : r_stab + STAB_W'(1);
      end
      w_exp = expected_y(DATA_PATTERN, en, sel);
      w_cmp = (r_state == RUN) && (w_stab == STAB_W'(D));
      w_mis = w_cmp && (w_y_s != w_exp);
   end

   // Next-state and status update.
   always_comb begin
      w_state_next    = r_state;
      w_err_next      = r_err_cnt;
      w_fail_next     = r_fail;
      w_ch_ok_next    = r_ch_ok;
      w_ch_bad_next   = r_ch_bad;
      w_off_seen_next = r_off_seen;

      case (r_state)
         IDLE: begin
            w_err_next      = '0;
            w_fail_next     = 1'b0;
            w_ch_ok_next    = '0;
            w_ch_bad_next   = '0;
            w_off_seen_next = 1'b0;
            w_state_next    = RUN;
         end
         RUN: begin
            if (w_cmp) begin
               if (!en) w_off_seen_next = 1'b1;
               if (w_mis) begin
                  if (r_err_cnt != '1) w_err_next = r_err_cnt + ERR_W'(1);
                  w_fail_next = 1'b1;
                  if (en) w_ch_bad_next[sel] = 1'b1;
               end else if (en) begin
                  w_ch_ok_next[sel] = 1'b1;
               end
            end
            // The final compare's result counts toward the DONE decision.
            if (((w_ch_ok_next | w_ch_bad_next) == '1) && w_off_seen_next) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            w_state_next = DONE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      if (!enable) begin
         w_state_next    = IDLE;
         w_err_next      = '0;
         w_fail_next     = 1'b0;
         w_ch_ok_next    = '0;
         w_ch_bad_next   = '0;
         w_off_seen_next = 1'b0;
      end

      w_busy_next = (w_state_next == RUN);
      w_done_next = (w_state_next == DONE);
      w_pass_next = w_done_next && (w_err_next == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_prev_stim <= '0;
         r_stab      <= '0;
         r_err_cnt   <= '0;
         r_fail      <= 1'b0;
         r_ch_ok     <= '0;
         r_ch_bad    <= '0;
         r_off_seen  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_prev_stim <= w_stim;
         r_stab      <= enable ? w_stab : '0;
         r_err_cnt   <= w_err_next;
         r_fail      <= w_fail_next;
         r_ch_ok     <= w_ch_ok_next;
         r_ch_bad    <= w_ch_bad_next;
         r_off_seen  <= w_off_seen_next;
         r_busy      <= w_busy_next;
         r_done      <= w_done_next;
         r_pass      <= w_pass_next;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign pass    = r_pass;
   assign fail    = r_fail;
   assign err_cnt = r_err_cnt;
   assign ch_ok   = r_ch_ok;
   assign ch_bad  = r_ch_bad;

endmodule

// File: tb/tb_mux_response_checker.sv
// Scoreboard bench for mux_response_checker with a behavioural mux IC model.
module tb_mux_response_checker;

   localparam int unsigned HOLD = 5;
   localparam int unsigned D    = 3;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       en;
   logic [2:0] sel;
   logic       y;
   logic       busy, done, pass, fail;
   logic [7:0] err_cnt, ch_ok, ch_bad;

   logic [7:0] pat = 8'hA5;
   int         fault = 0;

   typedef struct {
      int         tag;
      logic       busy, done, pass, fail;
      logic [7:0] err, ok, bad;
   } exp_t;

   exp_t sb_q[$];
   event chk_ev;
   int   total = 0;
   int   bad   = 0;

   mux_response_checker dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .en      (en),
      .sel     (sel),
      .y       (y),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .fail    (fail),
      .err_cnt (err_cnt),
      .ch_ok   (ch_ok),
      .ch_bad  (ch_bad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mux IC model: 0 ideal, 1 channel 3 stuck-at-1, 2 output stuck-at-1.
   always_comb begin
      y = en & pat[sel];
      if (fault == 1 && en && sel == 3'd3) y = 1'b1;
      if (fault == 2) y = 1'b1;
   end

   task automatic cmp(input int tag, input string nm, input logic [7:0] act, input logic [7:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL t%0d %s got=%0h want=%0h", tag, nm, act, want);
      end
   endtask

   always @(chk_ev) begin
      while (sb_q.size() != 0) begin
         exp_t x;
         x = sb_q.pop_front();
         cmp(x.tag, "busy",    8'(busy),  8'(x.busy));
         cmp(x.tag, "done",    8'(done),  8'(x.done));
         cmp(x.tag, "pass",    8'(pass),  8'(x.pass));
         cmp(x.tag, "fail",    8'(fail),  8'(x.fail));
         cmp(x.tag, "err_cnt", err_cnt,   x.err);
         cmp(x.tag, "ch_ok",   ch_ok,     x.ok);
         cmp(x.tag, "ch_bad",  ch_bad,    x.bad);
      end
   end

   task automatic expect_st(input int tag, input logic b, input logic d, input logic p,
                            input logic f, input logic [7:0] e, input logic [7:0] o,
                            input logic [7:0] k);
      exp_t x;
      x.tag = tag; x.busy = b; x.done = d; x.pass = p; x.fail = f;
      x.err = e; x.ok = o; x.bad = k;
      sb_q.push_back(x);
      ->chk_ev;
      #1;
   endtask

   task automatic stim(input logic e, input logic [2:0] s, input int cycles);
      en  = e;
      sel = s;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic sweep(input int n, input bit off);
      for (int c = 0; c < n; c++) stim(1'b1, 3'(c), HOLD);
      if (off) stim(1'b0, 3'd0, HOLD);
   endtask

   task automatic wait_done(input int tag);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (done !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL t%0d done_timeout got=0 want=1", tag);
      end
   endtask

   task automatic go_idle();
      enable = 1'b0;
      en     = 1'b0;
      sel    = 3'd0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; en = 1'b0; sel = 3'd0; fault = 0;
      #2;
      expect_st(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Ideal IC, full sweep including the disabled phase.
      enable = 1'b1;
      sweep(8, 1'b1);
      wait_done(1);
      expect_st(1, 0, 1, 1, 0, 8'h00, 8'hFF, 8'h00);
      go_idle();
      expect_st(11, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);

      // Channel 3 stuck-at-1: one error per settled compare on ch3.
      fault = 1;
      enable = 1'b1;
      sweep(8, 1'b1);
      wait_done(2);
      expect_st(2, 0, 1, 0, 1, 8'(HOLD - D), 8'hF7, 8'h08);
      go_idle();

      // Stimulus never stable: no compares even with a broken IC.
      fault = 2;
      enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         {en, sel} = 4'(i);
         @(negedge clk);
      end
      expect_st(3, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      go_idle();

      // Output stuck high against en=0: error count saturates without wrapping.
      fault = 2;
      enable = 1'b1;
      en = 1'b0;
      sel = 3'd0;
      repeat (300) @(negedge clk);
      expect_st(4, 1, 0, 0, 1, 8'hFF, 8'h00, 8'h00);
      repeat (20) @(negedge clk);
      expect_st(41, 1, 0, 0, 1, 8'hFF, 8'h00, 8'h00);
      go_idle();

      // enable dropped mid-sweep, then a full re-run.
      fault = 0;
      enable = 1'b1;
      sweep(3, 1'b0);
      expect_st(5, 1, 0, 0, 0, 8'h00, 8'h07, 8'h00);
      enable = 1'b0;
      @(negedge clk);
      expect_st(51, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      enable = 1'b1;
      sweep(8, 1'b1);
      wait_done(52);
      expect_st(52, 0, 1, 1, 0, 8'h00, 8'hFF, 8'h00);
      go_idle();

      // Asynchronous reset between edges, then DONE held with enable high.
      enable = 1'b1;
      sweep(4, 1'b0);
      expect_st(6, 1, 0, 0, 0, 8'h00, 8'h0F, 8'h00);
      #1 rst = 1'b1;
      #1;
      expect_st(61, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      sweep(8, 1'b1);
      wait_done(62);
      expect_st(62, 0, 1, 1, 0, 8'h00, 8'hFF, 8'h00);
      fault = 2;
      for (int i = 0; i < 10; i++) begin
         {en, sel} = 4'(i);
         @(negedge clk);
      end
      stim(1'b1, 3'd3, 10);
      expect_st(63, 0, 1, 1, 0, 8'h00, 8'hFF, 8'h00);
      enable = 1'b0;
      @(negedge clk);
      expect_st(64, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);

      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
